// File: rtl/qdma_c2h_sink.sv
// rtl/qdma_c2h_sink.sv - QDMA C2H receive model: framing check, completion matching, status pulses
// Accepts C2H data beats, matches completions against a qid FIFO, and counts statistics.
module qdma_c2h_sink #(
    parameter int          CMPT_FIFO_DEPTH = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic         axi_aclk,
    input  logic         axi_aresetn,
    input  logic         bp_en,
    input  logic [511:0] s_axis_c2h_tdata,
    input  logic [15:0]  s_axis_c2h_ctrl_len,
    input  logic [10:0]  s_axis_c2h_ctrl_qid,
    input  logic [2:0]   s_axis_c2h_ctrl_port_id,
    input  logic         s_axis_c2h_ctrl_has_cmpt,
    input  logic [5:0]   s_axis_c2h_mty,
    input  logic         s_axis_c2h_tvalid,
    input  logic         s_axis_c2h_tlast,
    output logic         s_axis_c2h_tready,
    input  logic         s_axis_c2h_cmpt_tvalid,
    input  logic [10:0]  s_axis_c2h_cmpt_ctrl_qid,
    output logic         s_axis_c2h_cmpt_tready,
    output logic         axis_c2h_status_valid,
    output logic         axis_c2h_status_last,
    output logic         axis_c2h_status_cmp,
    output logic         axis_c2h_status_error,
    output logic         axis_c2h_status_drop,
    output logic [10:0]  axis_c2h_status_qid,
    output logic         axis_c2h_dmawr_cmp,
    output logic [31:0]  pkt_cnt,
    output logic [47:0]  byte_cnt,
    output logic [15:0]  err_cnt,
    output logic [31:0]  cmpt_cnt
);

    localparam int AW = (CMPT_FIFO_DEPTH > 1) ? $clog2(CMPT_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(CMPT_FIFO_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   qid_q, qid_d;
    logic [2:0]    port_q, port_d;
    logic [15:0]   len_q, len_d;
    logic          hc_q, hc_d;
    logic [31:0]   acc_q, acc_d;
    logic          err_q, err_d;

    logic          st_valid_q, st_valid_d;
    logic [10:0]   st_qid_q, st_qid_d;
    logic          st_err_q, st_err_d;
    logic          st_cmp_q, st_cmp_d;
    logic [15:0]   st_len_q, st_len_d;

    logic [10:0]   fifo_mem_q [CMPT_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [15:0]   lfsr_q, lfsr_d;
    logic          tready_q, tready_d;
    logic          dmawr_q, dmawr_d;
    logic [31:0]   pkt_cnt_q, pkt_cnt_d;
    logic [47:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [31:0]   cmpt_cnt_q, cmpt_cnt_d;

    logic          beat_acc;
    logic [6:0]    beat_bytes;
    logic          beat_err;
    logic          fld_mis;
    logic [31:0]   acc_sum;
    logic          err_cur;
    logic [10:0]   pkt_qid;
    logic [15:0]   pkt_len;
    logic          pkt_hc;

    logic          push, pop, bypass, wr_en;
    logic          fifo_empty, fifo_full;
    logic [10:0]   cmp_qid;
    logic          cmpt_match, cmpt_err;
    logic [CW-1:0] rsv;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;

    logic          unused_tdata;
    assign unused_tdata = ^s_axis_c2h_tdata;

    assign beat_acc = s_axis_c2h_tvalid & tready_q;

    // Packet framing FSM: latch first-beat control, accumulate bytes, raise status on tlast
    always_comb begin
        state_d    = state_q;
        qid_d      = qid_q;
        port_d     = port_q;
        len_d      = len_q;
        hc_d       = hc_q;
        acc_d      = acc_q;
        err_d      = err_q;
        st_valid_d = 1'b0;
        st_qid_d   = st_qid_q;
        st_err_d   = 1'b0;
        st_cmp_d   = 1'b0;
        st_len_d   = st_len_q;
        acc_sum    = acc_q;
        err_cur    = err_q;
        pkt_qid    = qid_q;
        pkt_len    = len_q;
        pkt_hc     = hc_q;

        beat_bytes = s_axis_c2h_tlast ? (7'd64 - {1'b0, s_axis_c2h_mty}) : 7'd64;
        beat_err   = ((s_axis_c2h_mty != 6'd0) & ~s_axis_c2h_tlast) |
                     (s_axis_c2h_ctrl_len == 16'd0);
        fld_mis    = (s_axis_c2h_ctrl_qid != qid_q) |
                     (s_axis_c2h_ctrl_port_id != port_q) |
                     (s_axis_c2h_ctrl_len != len_q) |
                     (s_axis_c2h_ctrl_has_cmpt != hc_q);

        if (beat_acc) begin
            if (state_q == IDLE) begin
                qid_d   = s_axis_c2h_ctrl_qid;
                port_d  = s_axis_c2h_ctrl_port_id;
                len_d   = s_axis_c2h_ctrl_len;
                hc_d    = s_axis_c2h_ctrl_has_cmpt;
                acc_sum = {25'd0, beat_bytes};
                err_cur = beat_err;
                pkt_qid = s_axis_c2h_ctrl_qid;
                pkt_len = s_axis_c2h_ctrl_len;
                pkt_hc  = s_axis_c2h_ctrl_has_cmpt;
            end else begin
                acc_sum = acc_q + {25'd0, beat_bytes};
                err_cur = err_q | beat_err | fld_mis;
            end
            acc_d = acc_sum;
            err_d = err_cur;
            if (s_axis_c2h_tlast) begin
                state_d    = IDLE;
                st_valid_d = 1'b1;
                st_qid_d   = pkt_qid;
                st_err_d   = err_cur | (acc_sum != {16'd0, pkt_len});
                st_cmp_d   = pkt_hc & ~st_err_d;
                st_len_d   = pkt_len;
            end else begin
                state_d = IN_PKT;
            end
        end
    end

    // Completion FIFO; a completion arriving with an empty FIFO compares against a same-cycle push
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        push       = st_valid_q & st_cmp_q;
        pop        = s_axis_c2h_cmpt_tvalid & ~fifo_empty;
        bypass     = s_axis_c2h_cmpt_tvalid & fifo_empty & push;
        wr_en      = push & ~bypass & (~fifo_full | pop);
        cmp_qid    = fifo_empty ? st_qid_q : fifo_mem_q[rd_ptr_q];
        cmpt_match = s_axis_c2h_cmpt_tvalid & (pop | bypass) &
                     (cmp_qid == s_axis_c2h_cmpt_ctrl_qid);
        cmpt_err   = s_axis_c2h_cmpt_tvalid & ~cmpt_match;

        wr_ptr_d   = wr_ptr_q + AW'(wr_en);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(wr_en) - CW'(pop);

        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        // Reserve a slot for a push already in the status pipe so the FIFO can never overflow
        rsv        = count_d + CW'(st_cmp_d);
        tready_d   = (rsv < DEPTH_C) & (~bp_en | lfsr_d[0]);

        dmawr_d    = cmpt_match;
        pkt_cnt_d  = pkt_cnt_q + 32'(st_valid_q & ~st_err_q);
        byte_cnt_d = byte_cnt_q + ((st_valid_q & ~st_err_q) ? {32'd0, st_len_q} : 48'd0);
        cmpt_cnt_d = cmpt_cnt_q + 32'(cmpt_match);
        err_inc    = {1'b0, st_valid_q & st_err_q} + {1'b0, cmpt_err};
        err_sum    = {1'b0, err_cnt_q} + {15'd0, err_inc};
        err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= st_qid_q;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q    <= IDLE;
            qid_q      <= '0;
            port_q     <= '0;
            len_q      <= '0;
            hc_q       <= 1'b0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            st_valid_q <= 1'b0;
            st_qid_q   <= '0;
            st_err_q   <= 1'b0;
            st_cmp_q   <= 1'b0;
            st_len_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            tready_q   <= 1'b0;
            dmawr_q    <= 1'b0;
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
            cmpt_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            qid_q      <= qid_d;
            port_q     <= port_d;
            len_q      <= len_d;
            hc_q       <= hc_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            st_valid_q <= st_valid_d;
            st_qid_q   <= st_qid_d;
            st_err_q   <= st_err_d;
            st_cmp_q   <= st_cmp_d;
            st_len_q   <= st_len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lfsr_q     <= lfsr_d;
            tready_q   <= tready_d;
            dmawr_q    <= dmawr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            err_cnt_q  <= err_cnt_d;
            cmpt_cnt_q <= cmpt_cnt_d;
        end
    end

    assign s_axis_c2h_tready      = tready_q;
    assign s_axis_c2h_cmpt_tready = 1'b1;
    assign axis_c2h_status_valid  = st_valid_q;
    assign axis_c2h_status_last   = st_valid_q;
    assign axis_c2h_status_cmp    = st_cmp_q;
    assign axis_c2h_status_error  = st_err_q;
    assign axis_c2h_status_drop   = st_err_q;
    assign axis_c2h_status_qid    = st_qid_q;
    assign axis_c2h_dmawr_cmp     = dmawr_q;
    assign pkt_cnt                = pkt_cnt_q;
    assign byte_cnt               = byte_cnt_q;
    assign err_cnt                = err_cnt_q;
    assign cmpt_cnt               = cmpt_cnt_q;

endmodule

// File: doc/qdma_c2h_sink.md
Name: qdma_c2h_sink

Overview:
Synthesizable C2H receive model for QDMA simulation. It sits on the shell's s_axis_c2h data and s_axis_c2h_cmpt completion streams, opposite the H2C packet driver. It checks packet framing, matches each completion to a received packet, produces QDMA-style axis_c2h_status/dmawr_cmp pulses, and applies optional pseudo-random backpressure. Statistics counters are exposed for the testbench.

Parameters:
CMPT_FIFO_DEPTH, 8, pending-completion qid FIFO entries (power of 2, >=2)
LFSR_SEED, 16'hACE1, backpressure LFSR reset value (non-zero)

Ports:
axi_aclk  in  1  clock, 250 MHz
axi_aresetn  in  1  asynchronous active-low reset
bp_en  in  1  1 = pseudo-random tready backpressure
s_axis_c2h_tdata  in  512  payload (not checked)
s_axis_c2h_ctrl_len  in  16  packet byte length
s_axis_c2h_ctrl_qid  in  11  queue id
s_axis_c2h_ctrl_port_id  in  3  port id
s_axis_c2h_ctrl_has_cmpt  in  1  packet expects a completion
s_axis_c2h_mty  in  6  empty bytes, last beat only
s_axis_c2h_tvalid / tlast  in  1  data handshake / end of packet
s_axis_c2h_tready  out  1  data ready
s_axis_c2h_cmpt_tvalid  in  1  completion valid
s_axis_c2h_cmpt_ctrl_qid  in  11  completion queue id
s_axis_c2h_cmpt_tready  out  1  completion ready
axis_c2h_status_valid / last / cmp / error / drop  out  1  status pulse and flags
axis_c2h_status_qid  out  11  status queue id
axis_c2h_dmawr_cmp  out  1  matched-completion pulse
pkt_cnt  out  32  good packets
byte_cnt  out  48  bytes of good packets
err_cnt  out  16  framing and completion errors, saturating
cmpt_cnt  out  32  matched completions

Behaviour:
- Reset: all outputs 0 except s_axis_c2h_cmpt_tready = 1. s_axis_c2h_tready is 0 during reset and 1 afterwards. FSM is IDLE, FIFO is empty, LFSR = LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
- s_axis_c2h_tready = !fifo_full & (!bp_en | lfsr[0]). It is registered from the next-state values.
- A beat is accepted when tvalid & tready.
- FSM IDLE: an accepted beat is the first beat. Latch qid, port_id, len and has_cmpt. acc = beat_bytes. Go to IN_PKT unless tlast is set.
- FSM IN_PKT: on each accepted beat, acc += beat_bytes. Any ctrl field that differs from the latched value sets the sticky err flag. tlast returns the FSM to IDLE.
- beat_bytes = tlast ? 64 - mty : 64.
- The err flag is set by any of:
  - non-zero mty on a non-last beat
  - ctrl_len == 0
  - total bytes != latched len on the last beat
  - mty == 0 when the length is not a multiple of 64 is not an error by itself; only the total counts.
- Status: exactly one cycle after the last beat, axis_c2h_status_valid = 1 for one cycle. Flags: last = 1, qid = latched qid, error = err, drop = err, cmp = has_cmpt & !err.
- Good packet (!err): pkt_cnt += 1 and byte_cnt += len, in the status cycle. Bad packet: err_cnt += 1.
- Completion FIFO: in the status cycle, if cmp = 1, push the qid.
- Completion accept: s_axis_c2h_cmpt_tready is always 1. An accepted completion pops the FIFO head and compares qids.
  - Match: axis_c2h_dmawr_cmp pulses the next cycle and cmpt_cnt += 1.
  - Mismatch: err_cnt += 1.
- Completion on an empty FIFO:
  - If a push happens in the same cycle, compare against the pushed qid; nothing is stored and the FIFO stays empty.
  - Otherwise err_cnt += 1.
- Simultaneous push and pop on a non-empty FIFO: both happen and the occupancy is unchanged.
- FIFO full: tready drops, so no new beat is accepted until a pop. The packet in flight completes its status cycle.
- Counters: pkt_cnt, byte_cnt and cmpt_cnt wrap; err_cnt saturates at 16'hFFFF. Two err_cnt increments in one cycle (packet error plus completion error) add 2.
- Reset mid-packet: everything clears asynchronously with no status pulse. The first beat accepted after reset is treated as a first beat.

Test Plan:
- qid 5, has_cmpt = 1, len 100: two beats (mty 0, then mty 28 with tlast) -> one status pulse with qid = 5, cmp = 1, error = 0. pkt_cnt = 1, byte_cnt = 100. A completion with qid 5 then gives a dmawr_cmp pulse and cmpt_cnt = 1.
- len 100 sent as 2 beats with last mty 0 (128 bytes) -> status error = 1, drop = 1, cmp = 0. err_cnt = 1, pkt_cnt = 0, no FIFO push.
- 8 has_cmpt packets with no completions, CMPT_FIFO_DEPTH = 8 -> tready = 0 after the 8th status cycle. One completion (qid matching the head) -> tready returns to 1 on the next cycle.
- Completion qid 7 when the FIFO head is qid 3 -> err_cnt += 1, no dmawr_cmp, head popped. Completion in the same cycle as the status push of qid 9 with an empty FIFO -> match and cmpt_cnt += 1.
- bp_en = 1, 50 back-to-back 1-beat packets -> tready toggles per the LFSR. All 50 status pulses are seen, pkt_cnt = 50, no lost or duplicated beats.
- axi_aresetn driven low after beat 1 of a 3-beat packet, released, then a fresh 1-beat len 64 packet -> no status pulse for the aborted packet. pkt_cnt = 1, byte_cnt = 64, err_cnt = 0.
